// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer with HI/LO ownership for the pipelined MIPS core.
// Optional MD_CANCEL_EN adds a 'cancel' input that aborts an in-flight op or a start.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [15:0] MULT_LOAD = 16'(MULT_CYCLES);
  localparam logic [15:0] DIV_LOAD  = 16'(DIV_CYCLES);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [2:0]  op_r, op_s;
  logic [31:0] a_r, a_s, b_r, b_s;
  logic [31:0] hi_r, hi_s, lo_r, lo_s;
  logic        done_r, done_s;
  logic        cancel_s;

`ifdef MD_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  // Datapath results, always derived from the latched operands only.
  logic [63:0] sprod_s, uprod_s;
  logic        a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s, mq_s, mr_s, squot_s, srem_s, uquot_s, urem_s;

  assign sprod_s = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
  assign uprod_s = {32'd0, a_r} * {32'd0, b_r};
  assign a_neg_s = a_r[31];
  assign b_neg_s = b_r[31];
  assign a_mag_s = a_neg_s ? (32'd0 - a_r) : a_r;
  assign b_mag_s = b_neg_s ? (32'd0 - b_r) : b_r;
  // Magnitude divide: 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
  assign mq_s    = (b_mag_s == 32'd0) ? 32'd0 : (a_mag_s / b_mag_s);
  assign mr_s    = (b_mag_s == 32'd0) ? 32'd0 : (a_mag_s % b_mag_s);
  assign squot_s = (a_neg_s ^ b_neg_s) ? (32'd0 - mq_s) : mq_s;
  assign srem_s  = a_neg_s ? (32'd0 - mr_s) : mr_s;
  assign uquot_s = (b_r == 32'd0) ? 32'd0 : (a_r / b_r);
  assign urem_s  = (b_r == 32'd0) ? 32'd0 : (a_r % b_r);

  // Next-state, counter, operand latch and HI/LO commit logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !cancel_s) begin
          case (op)
            3'd0, 3'd1: begin
              op_s = op; a_s = a; b_s = b;
              cnt_s = MULT_LOAD;
              state_s = RUN;
            end
            3'd2, 3'd3: begin
              op_s = op; a_s = a; b_s = b;
              cnt_s = DIV_LOAD;
              state_s = RUN;
            end
            3'd4:    hi_s = a;
            3'd5:    lo_s = a;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cancel_s) begin
          state_s = IDLE;
          cnt_s   = 16'd0;
        end else if (cnt_r == 16'd1) begin
          state_s = IDLE;
          cnt_s   = 16'd0;
          done_s  = 1'b1;
          case (op_r)
            3'd0: {hi_s, lo_s} = sprod_s;
            3'd1: {hi_s, lo_s} = uprod_s;
            3'd2: begin
              if (b_r != 32'd0) begin
                hi_s = srem_s;
                lo_s = squot_s;
              end else begin
                hi_s = hi_r;
                lo_s = lo_r;
              end
            end
            3'd3: begin
              if (b_r != 32'd0) begin
                hi_s = urem_s;
                lo_s = uquot_s;
              end else begin
                hi_s = hi_r;
                lo_s = lo_r;
              end
            end
            default: done_s = 1'b1;
          endcase
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and architectural register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      op_r    <= 3'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      done_r  <= done_s;
    end
  end

  assign busy = (state_r == RUN);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (default parameters 5/10).
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns in cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
  endtask

  // Count remaining busy cycles (bounded); returns in the first non-busy cycle.
  task automatic wait_idle(output int n, output bit early_done);
    n = 0;
    early_done = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (done === 1'b1) early_done = 1'b1;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_mult();
    int n; bit ed;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(n, ed);
    tests_run++;
    if (n !== 5 || ed) begin
      tests_failed++;
      $display("FAIL mult_busy: busy_cycles=%0d early_done=%0d, required 5 0", n, ed);
    end
    tests_run++;
    if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      tests_failed++;
      $display("FAIL mult_result: done=%b hi=%h lo=%h, required 1 ffffffff fffffffa", done, hi, lo);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_multu();
    int n; bit ed;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n, ed);
    tests_run++;
    if (n !== 5 || done !== 1'b1 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL multu: cycles=%0d done=%b hi=%h lo=%h, required 5 1 fffffffe 00000001", n, done, hi, lo);
    end
  endtask

  task automatic test_div();
    int n; bit ed;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n, ed);
    tests_run++;
    if (n !== 10 || done !== 1'b1 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL div_neg7_2: cycles=%0d done=%b hi=%h lo=%h, required 10 1 ffffffff fffffffd", n, done, hi, lo);
    end
    tick();
    issue(3'd3, 32'd7, 32'd0);
    wait_idle(n, ed);
    tests_run++;
    if (n !== 10 || done !== 1'b1 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL divu_by_zero: cycles=%0d done=%b hi=%h lo=%h, required 10 1 ffffffff fffffffd", n, done, hi, lo);
    end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n, ed);
    tests_run++;
    if (lo !== 32'h80000000 || hi !== 32'h00000000) begin
      tests_failed++;
      $display("FAIL div_overflow: hi=%h lo=%h, required 00000000 80000000", hi, lo);
    end
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    wait_idle(n, ed);
    tests_run++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL div_7_neg2: hi=%h lo=%h, required 00000001 fffffffd", hi, lo);
    end
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n, ed);
    tests_run++;
    if (lo !== 32'h7FFFFFFC || hi !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL divu_big: hi=%h lo=%h, required 00000001 7ffffffc", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    bit saw_busy;
    saw_busy = 1'b0;
    start = 1'b1; op = 3'd4; a = 32'h1234; b = 32'd0;
    tick();
    if (busy !== 1'b0) saw_busy = 1'b1;
    tests_run++;
    if (hi !== 32'h1234) begin
      tests_failed++;
      $display("FAIL mthi: hi=%h, required 00001234", hi);
    end
    op = 3'd5; a = 32'h5678;
    tick();
    start = 1'b0;
    if (busy !== 1'b0) saw_busy = 1'b1;
    tests_run++;
    if (hi !== 32'h1234 || lo !== 32'h5678 || saw_busy || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo: hi=%h lo=%h saw_busy=%0d done=%b, required 00001234 00005678 0 0", hi, lo, saw_busy, done);
    end
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      tests_failed++;
      $display("FAIL reserved_op: busy=%b done=%b hi=%h lo=%h, required 0 0 00001234 00005678", busy, done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit ed;
    issue(3'd2, 32'd100, 32'd7);
    tick(); tick();
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0; a = 32'hFFFFFFFF; b = 32'd1;
    tick();
    a = 32'd3; b = 32'd0;
    wait_idle(n, ed);
    tests_run++;
    if (n + 4 !== 10 || lo !== 32'd14 || hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL start_in_run: cycles=%0d hi=%h lo=%h, required 10 00000002 0000000e", n + 4, hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    issue(3'd0, 32'd9, 32'd9);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort_after: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

`ifdef MD_CANCEL_EN
  task automatic test_cancel();
    issue(3'd5, 32'hCAFE, 32'd0);
    issue(3'd0, 32'd4, 32'd4);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'hCAFE) begin
      tests_failed++;
      $display("FAIL cancel_run: busy=%b done=%b lo=%h, required 0 0 0000cafe", busy, done, lo);
    end
    cancel = 1'b1;
    issue(3'd4, 32'hBAD, 32'd0);
    cancel = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL cancel_start: busy=%b hi=%h, required 0 00000000", busy, hi);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_abort();
`ifdef MD_CANCEL_EN
    test_cancel();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
